// File: rtl/cpu6_pipeline_ctrl_pkg.sv
// Shared types and constants for the cpu6 hazard/serialization controller.
// State encoding is fixed so the registered state can live in a plain flop.
package cpu6_pipeline_ctrl_pkg;

    localparam int STATE_W              = 1;
    localparam int DRAIN_CNT_W          = 3;
    localparam int DEFAULT_DRAIN_STAGES = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } pctrl_state_e;

    function automatic logic is_redirect(input logic branch_taken, input logic jump);
        return branch_taken | jump;
    endfunction

endpackage

// File: rtl/cpu6_dffr.sv
// Generic register with synchronous active-high reset to a parameterised value.
module cpu6_dffr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Storage with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/cpu6_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instr in D.
// Kept standalone so the forwarding unit can reuse the same compare later.
module cpu6_hazard_detect #(
    parameter int REGADDR_W = 5
) (
    input  logic [REGADDR_W-1:0] rs1D,
    input  logic [REGADDR_W-1:0] rs2D,
    input  logic                 rs1_usedD,
    input  logic                 rs2_usedD,
    input  logic [REGADDR_W-1:0] rdE,
    input  logic                 memtoregE,
    output logic                 loaduse
);

    logic rd_nonzero_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // x0 is hardwired zero, so a load into it never creates a dependency
    assign rd_nonzero_s = (rdE != {REGADDR_W{1'b0}});
    assign rs1_hit_s    = rs1_usedD & (rs1D == rdE);
    assign rs2_hit_s    = rs2_usedD & (rs2D == rdE);
    assign loaduse      = memtoregE & rd_nonzero_s & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/cpu6_pipeline_ctrl.sv
// Stall/bubble controller for the cpu6 5-stage pipeline: load-use stalls,
// EX redirects, and a drain window after serializing instructions.
module cpu6_pipeline_ctrl
    import cpu6_pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_STAGES = DEFAULT_DRAIN_STAGES,
    parameter int REGADDR_W    = 5,
    parameter int PERF_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REGADDR_W-1:0]   rs1D,
    input  logic [REGADDR_W-1:0]   rs2D,
    input  logic                   rs1_usedD,
    input  logic                   rs2_usedD,
    input  logic [REGADDR_W-1:0]   rdE,
    input  logic                   memtoregE,
    input  logic                   branch_takenE,
    input  logic                   jumpE,
    input  logic                   empty_pipeline_reqE,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   flashD,
    output logic                   flashE,
    output logic                   drain_busy,
    output logic [DRAIN_CNT_W-1:0] drain_cnt,
    output logic [PERF_W-1:0]      stall_cycles
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_STAGES);

    logic [STATE_W-1:0]     state_r;
    logic [STATE_W-1:0]     state_nxt_s;
    logic [DRAIN_CNT_W-1:0] cnt_r;
    logic [DRAIN_CNT_W-1:0] cnt_nxt_s;
    logic [PERF_W-1:0]      perf_r;
    logic [PERF_W-1:0]      perf_nxt_s;
    logic                   loaduse_s;
    logic                   redirect_s;

    cpu6_hazard_detect #(.REGADDR_W(REGADDR_W)) u_hazard (
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .rs1_usedD (rs1_usedD),
        .rs2_usedD (rs2_usedD),
        .rdE       (rdE),
        .memtoregE (memtoregE),
        .loaduse   (loaduse_s)
    );

    assign redirect_s = is_redirect(branch_takenE, jumpE);

    // Output decode and next-state; reset forces every output low in its own cycle
    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        flashD      = 1'b0;
        flashE      = 1'b0;
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (reset) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {DRAIN_CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect_s) begin
                        flashD = 1'b1;
                        flashE = 1'b1;
                    end else if (loaduse_s) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flashE = 1'b1;
                    end else begin
                        flashE = 1'b0;
                    end
                    // The serializing instr itself still advances; draining starts next cycle
                    if (empty_pipeline_reqE) begin
                        state_nxt_s = ST_DRAIN;
                        cnt_nxt_s   = DRAIN_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flashE = 1'b1;
                    if (cnt_r == 3'd1) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = {DRAIN_CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {DRAIN_CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Stall-cycle perf counter, free-running wrap
    always_comb begin
        if (stallD) begin
            perf_nxt_s = perf_r + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            perf_nxt_s = perf_r;
        end
    end

    cpu6_dffr #(.W(STATE_W), .RST_VAL(ST_IDLE)) u_state_ff (
        .clk (clk), .reset (reset), .d (state_nxt_s), .q (state_r)
    );

    cpu6_dffr #(.W(DRAIN_CNT_W), .RST_VAL({DRAIN_CNT_W{1'b0}})) u_cnt_ff (
        .clk (clk), .reset (reset), .d (cnt_nxt_s), .q (cnt_r)
    );

    cpu6_dffr #(.W(PERF_W), .RST_VAL({PERF_W{1'b0}})) u_perf_ff (
        .clk (clk), .reset (reset), .d (perf_nxt_s), .q (perf_r)
    );

    assign drain_busy   = ~reset & (state_r == ST_DRAIN);
    assign drain_cnt    = reset ? {DRAIN_CNT_W{1'b0}} : cnt_r;
    assign stall_cycles = reset ? {PERF_W{1'b0}} : perf_r;

endmodule

// File: tb/tb_cpu6_pipeline_ctrl.sv
// Table-driven bench for cpu6_pipeline_ctrl: each row is one clock cycle of
// inputs plus hand-derived outputs; expectations go through a scoreboard queue.
module tb_cpu6_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1D, rs2D, rdE;
    logic        rs1_usedD, rs2_usedD, memtoregE, branch_takenE, jumpE, empty_pipeline_reqE;
    logic        stallF, stallD, flashD, flashE, drain_busy;
    logic [2:0]  drain_cnt;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  flags;   // {stallF, stallD, flashD, flashE}
        logic        busy;
        logic [2:0]  cnt;
        logic [31:0] sc;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mem, br, jmp, req;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    cpu6_pipeline_ctrl #(.DRAIN_STAGES(3), .REGADDR_W(5), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1_usedD(rs1_usedD),
        .rs2_usedD(rs2_usedD), .rdE(rdE), .memtoregE(memtoregE),
        .branch_takenE(branch_takenE), .jumpE(jumpE),
        .empty_pipeline_reqE(empty_pipeline_reqE), .stallF(stallF), .stallD(stallD),
        .flashD(flashD), .flashE(flashE), .drain_busy(drain_busy), .drain_cnt(drain_cnt),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic m, input logic b, input logic j, input logic q,
                                input logic [3:0] fl, input logic bz, input logic [2:0] c,
                                input logic [31:0] sc);
        vec_t v;
        v.rst = r; v.rs1 = s1; v.rs2 = s2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mem = m; v.br = b; v.jmp = j; v.req = q;
        v.e.flags = fl; v.e.busy = bz; v.e.cnt = c; v.e.sc = sc;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    initial begin
        //          rst rs1  rs2  u1 u2 rd   mem br jmp req  flags   busy cnt sc
        vecs.push_back(mk(1, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1, 4'b0000, 0, 0, 0)); // reset overrides
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 4'b1101, 0, 0, 0)); // load-use rs1
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 1)); // bubble in E
        vecs.push_back(mk(0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 4'b0000, 0, 0, 1)); // x0 guard
        vecs.push_back(mk(0, 5'd7, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, 4'b1101, 0, 0, 1)); // load-use rs2
        vecs.push_back(mk(0, 5'd7, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0, 4'b0000, 0, 0, 2)); // not used
        vecs.push_back(mk(0, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0, 0, 0, 4'b0000, 0, 0, 2)); // reg mismatch
        vecs.push_back(mk(0, 5'd9, 5'd0, 1, 0, 5'd9, 0, 0, 0, 0, 4'b0000, 0, 0, 2)); // not a load
        vecs.push_back(mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 4'b0011, 0, 0, 2)); // branch beats load-use
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 4'b0011, 0, 0, 2)); // jump
        // serialize, with hazard/redirect/req noise during DRAIN that must be ignored
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 4'b0000, 0, 0, 2));
        vecs.push_back(mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 1, 4'b1101, 1, 3, 2));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 4'b1101, 1, 2, 3));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 4'b1101, 1, 1, 4));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 5));
        // serializing jump
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 4'b0011, 0, 0, 5));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b1101, 1, 3, 5));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b1101, 1, 2, 6));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b1101, 1, 1, 7));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 8));
        // reset arriving at drain_cnt=2
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 4'b0000, 0, 0, 8));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b1101, 1, 3, 8));
        vecs.push_back(mk(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        // load-use coincident with serialize request
        vecs.push_back(mk(0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1, 4'b1101, 0, 0, 0));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b1101, 1, 3, 1));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b1101, 1, 2, 2));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b1101, 1, 1, 3));
        vecs.push_back(mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 0, 0, 4));

        reset = 1'b1; rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0; rs1_usedD = 1'b0; rs2_usedD = 1'b0;
        memtoregE = 1'b0; branch_takenE = 1'b0; jumpE = 1'b0; empty_pipeline_reqE = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            reset = vecs[i].rst; rs1D = vecs[i].rs1; rs2D = vecs[i].rs2; rdE = vecs[i].rd;
            rs1_usedD = vecs[i].u1; rs2_usedD = vecs[i].u2; memtoregE = vecs[i].mem;
            branch_takenE = vecs[i].br; jumpE = vecs[i].jmp; empty_pipeline_reqE = vecs[i].req;
            sb.push_back(vecs[i].e);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", i, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("stallF",       i, {31'd0, stallF},     {31'd0, e.flags[3]});
                chk("stallD",       i, {31'd0, stallD},     {31'd0, e.flags[2]});
                chk("flashD",       i, {31'd0, flashD},     {31'd0, e.flags[1]});
                chk("flashE",       i, {31'd0, flashE},     {31'd0, e.flags[0]});
                chk("drain_busy",   i, {31'd0, drain_busy}, {31'd0, e.busy});
                chk("drain_cnt",    i, {29'd0, drain_cnt},  {29'd0, e.cnt});
                chk("stall_cycles", i, stall_cycles,        e.sc);
            end
        end
        chk("scoreboard_leftover", vecs.size(), sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
